// File: rtl/stepper_pkg.sv
// Shared state encoding and default timing constants for the stepper pulse generator.
package stepper_pkg;

   localparam int CNT_W_DEF     = 16;
   localparam int PER_W_DEF     = 20;
   localparam int POS_W_DEF     = 24;
   localparam int DIR_SETUP_DEF = 4;
   localparam int MIN_HALF_DEF  = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      DONE
   } state_e;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; a phase of L cycles is timed by loading L-1 on phase entry.
module step_timer #(
   parameter int PER_W = 20
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load_i,
   input  logic [PER_W-1:0] load_val_i,
   output logic             expire_o
);

   logic [PER_W-1:0] count_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - PER_W'(1);
      end
   end

   assign expire_o = (count_q == '0);

endmodule

// File: rtl/stepper_step_gen.sv
// STEP/DIR pulse generator with valid/ready command intake and busy/done status.
// Define STEP_POS_EN to add the signed absolute position counter and pos output.
module stepper_step_gen
   import stepper_pkg::*;
#(
   parameter int CNT_W     = CNT_W_DEF,
   parameter int PER_W     = PER_W_DEF,
   parameter int DIR_SETUP = DIR_SETUP_DEF,
   parameter int MIN_HALF  = MIN_HALF_DEF
`ifdef STEP_POS_EN
   ,
   parameter int POS_W     = POS_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             cmd_dir,
   input  logic [PER_W-1:0] cmd_half,
   input  logic             abort,
   output logic             step,
   output logic             dir,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left
`ifdef STEP_POS_EN
   ,
   output logic [POS_W-1:0] pos
`endif
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] steps_q, steps_d;
   logic [PER_W-1:0] half_q, half_d;
   logic             dir_q, dir_d;
   logic             abort_q, abort_d;
   logic             step_q, done_q, busy_q, ready_q;
   logic             tmr_load, tmr_expire;
   logic [PER_W-1:0] tmr_val;
`ifdef STEP_POS_EN
   logic [POS_W-1:0] pos_q, pos_d;
`endif

   step_timer #(.PER_W(PER_W)) u_timer (
      .clk        (clk),
      .clr        (clr),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   // An abort seen during HIGH or LOW is remembered so the pulse finishes whole.
   always_comb begin
      state_d  = state_q;
      steps_d  = steps_q;
      half_d   = half_q;
      dir_d    = dir_q;
      abort_d  = abort_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
`ifdef STEP_POS_EN
      pos_d    = pos_q;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               dir_d   = cmd_dir;
               steps_d = cmd_steps;
               half_d  = (cmd_half < PER_W'(MIN_HALF)) ? PER_W'(MIN_HALF) : cmd_half;
               abort_d = 1'b0;
               if (cmd_steps == '0) begin
                  state_d = DONE;
               end else begin
                  state_d  = SETUP;
                  tmr_load = 1'b1;
                  tmr_val  = PER_W'(DIR_SETUP - 1);
               end
            end
         end
         SETUP: begin
            if (abort) begin
               state_d = DONE;
            end else if (tmr_expire) begin
               state_d  = HIGH;
               steps_d  = steps_q - CNT_W'(1);
               tmr_load = 1'b1;
               tmr_val  = half_q - PER_W'(1);
`ifdef STEP_POS_EN
               pos_d    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
`endif
            end
         end
         HIGH: begin
            abort_d = abort_q | abort;
            if (tmr_expire) begin
               state_d  = LOW;
               tmr_load = 1'b1;
               tmr_val  = half_q - PER_W'(1);
            end
         end
         LOW: begin
            abort_d = abort_q | abort;
            if (tmr_expire) begin
               if ((steps_q == '0) || abort_q || abort) begin
                  state_d = DONE;
               end else begin
                  state_d  = HIGH;
                  steps_d  = steps_q - CNT_W'(1);
                  tmr_load = 1'b1;
                  tmr_val  = half_q - PER_W'(1);
`ifdef STEP_POS_EN
                  pos_d    = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
`endif
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         steps_q <= '0;
         half_q  <= '0;
         dir_q   <= 1'b0;
         abort_q <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
`ifdef STEP_POS_EN
         pos_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         steps_q <= steps_d;
         half_q  <= half_d;
         dir_q   <= dir_d;
         abort_q <= abort_d;
         step_q  <= (state_d == HIGH);
         done_q  <= (state_d == DONE);
         busy_q  <= (state_d != IDLE);
         ready_q <= (state_d == IDLE);
`ifdef STEP_POS_EN
         pos_q   <= pos_d;
`endif
      end
   end

   assign cmd_ready  = ready_q;
   assign step       = step_q;
   assign dir        = dir_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign steps_left = steps_q;
`ifdef STEP_POS_EN
   assign pos        = pos_q;
`endif

endmodule

// File: tb/tb_stepper_step_gen.sv
// Scoreboard bench for stepper_step_gen: the driver pushes each move's expected outcome
// at acceptance, and a monitor measures STEP timing and checks it when done pulses.
module tb_stepper_step_gen;

   localparam int DIR_SETUP = 4;
   localparam int MIN_HALF  = 2;
   localparam int WAIT_MAX  = 3000;

   typedef struct {
      int accept;
      int half;
      bit dir;
      int pulses;
      int doneCycle;
      int stepsLeft;
   } exp_t;

   logic        clk = 1'b0;
   logic        clr;
   logic        cmdValid;
   logic        cmdReady;
   logic [15:0] cmdSteps;
   logic        cmdDir;
   logic [19:0] cmdHalf;
   logic        abortIn;
   logic        step;
   logic        dir;
   logic        busy;
   logic        done;
   logic [15:0] stepsLeft;
`ifdef STEP_POS_EN
   logic [23:0] pos;
`endif

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   lastDoneCycle = -100;
   int   modelPos = 0;
   exp_t sbq[$];

   stepper_step_gen dut (
      .clk        (clk),
      .clr        (clr),
      .cmd_valid  (cmdValid),
      .cmd_ready  (cmdReady),
      .cmd_steps  (cmdSteps),
      .cmd_dir    (cmdDir),
      .cmd_half   (cmdHalf),
      .abort      (abortIn),
      .step       (step),
      .dir        (dir),
      .busy       (busy),
      .done       (done),
      .steps_left (stepsLeft)
`ifdef STEP_POS_EN
      ,
      .pos        (pos)
`endif
   );

   always #5 clk = ~clk;

   // Cycle k in the bench's numbering is the cycle that ends at rising edge k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Drives one command; abortAt 0 = none, -1 = during SETUP, p>0 = one cycle into pulse p.
   task automatic applyStimulus(input int steps, input int half, input bit dr,
                                input int abortAt, input bit hold, input bit checkB2B);
      int   n;
      int   e0;
      int   rises;
      int   abortCycle;
      bit   prev;
      exp_t e;
      @(negedge clk);
      cmdSteps = 16'(steps);
      cmdHalf  = 20'(half);
      cmdDir   = dr;
      cmdValid = 1'b1;
      n = 0;
      while (!cmdReady && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (!cmdReady) begin
         checkOutput("acceptTimeout", 0, 1);
         cmdValid = 1'b0;
         return;
      end
      e0 = cyc + 1;
      if (checkB2B) checkOutput("b2bAccept", e0, lastDoneCycle + 1);
      e.accept = e0;
      e.half   = (half < MIN_HALF) ? MIN_HALF : half;
      e.dir    = dr;
      if (abortAt < 0) begin
         e.pulses    = 0;
         e.doneCycle = e0 + 2;
      end else begin
         e.pulses    = (abortAt > 0) ? abortAt : steps;
         e.doneCycle = (steps == 0) ? e0 + 1 : e0 + DIR_SETUP + 1 + 2 * e.pulses * e.half;
      end
      e.stepsLeft = steps - e.pulses;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (!hold) cmdValid = 1'b0;
      cmdSteps = 16'($urandom);
      cmdHalf  = 20'($urandom);
      if (abortAt < 0) abortIn = 1'b1;
      if (hold) return;
      rises = 0;
      prev = 1'b0;
      abortCycle = -1;
      n = 0;
      while (!done && n < WAIT_MAX) begin
         if (step && !prev) begin
            rises++;
            if (rises == abortAt) abortCycle = cyc + 2;
         end
         if (cyc + 1 == abortCycle) abortIn = 1'b1;
         prev = step;
         @(negedge clk);
         n++;
      end
      if (!done) checkOutput("doneTimeout", 0, 1);
      abortIn = 1'b0;
   endtask

   // Monitor: measures pulse shape against the move at the head of the scoreboard.
   initial begin : monitor
      exp_t cur;
      int   mRises = 0;
      int   mHigh = 0;
      int   mLow = 0;
      int   mDirErr = 0;
      bit   mPrev = 1'b0;
      bit   idleCheck = 1'b0;
      forever begin
         @(negedge clk);
         if (clr) begin
            if (idleCheck) begin
               checkOutput("idleBusy", int'(busy), 0);
               checkOutput("idleReady", int'(cmdReady), 1);
               idleCheck = 1'b0;
            end
            if (done) begin
               if (sbq.size() == 0) begin
                  checkOutput("spuriousDone", 1, 0);
               end else begin
                  cur = sbq.pop_front();
                  lastDoneCycle = cyc + 1;
                  checkOutput("doneCycle", cyc + 1, cur.doneCycle);
                  checkOutput("pulses", mRises, cur.pulses);
                  checkOutput("stepsLeft", int'(stepsLeft), cur.stepsLeft);
                  checkOutput("dirErrors", mDirErr, 0);
                  checkOutput("busyAtDone", int'(busy), 1);
                  checkOutput("readyAtDone", int'(cmdReady), 0);
                  if (cur.pulses > 0) checkOutput("lastLow", mLow, cur.half);
                  modelPos = cur.dir ? modelPos + cur.pulses : modelPos - cur.pulses;
`ifdef STEP_POS_EN
                  checkOutput("pos", int'(pos), modelPos & 32'h00FF_FFFF);
`endif
                  idleCheck = 1'b1;
               end
               mRises = 0;
               mHigh = 0;
               mLow = 0;
               mDirErr = 0;
               mPrev = 1'b0;
            end else if (sbq.size() > 0 && cyc >= sbq[0].accept) begin
               if (dir !== sbq[0].dir) mDirErr++;
               if (step) begin
                  if (!mPrev) begin
                     mRises++;
                     if (mRises == 1)
                        checkOutput("firstRise", cyc + 1, sbq[0].accept + DIR_SETUP + 1);
                     else
                        checkOutput("lowLen", mLow, sbq[0].half);
                     mHigh = 1;
                  end else begin
                     mHigh++;
                  end
               end else begin
                  if (mPrev) begin
                     checkOutput("highLen", mHigh, sbq[0].half);
                     mLow = 1;
                  end else begin
                     mLow++;
                  end
               end
               mPrev = step;
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int n;
      int s;
      int p;
      clr      = 1'b0;
      cmdValid = 1'b0;
      cmdSteps = '0;
      cmdDir   = 1'b0;
      cmdHalf  = '0;
      abortIn  = 1'b0;
      #12;
      checkOutput("rstStep", int'(step), 0);
      checkOutput("rstDir", int'(dir), 0);
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstReady", int'(cmdReady), 1);
      checkOutput("rstStepsLeft", int'(stepsLeft), 0);
`ifdef STEP_POS_EN
      checkOutput("rstPos", int'(pos), 0);
`endif
      @(negedge clk);
      clr = 1'b1;

      applyStimulus(3, 5, 1'b1, 0, 1'b0, 1'b0);
      applyStimulus(0, 7, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(2, 0, 1'b0, 0, 1'b0, 1'b0);
      applyStimulus(10, 4, 1'b1, 3, 1'b0, 1'b0);
      applyStimulus(5, 3, 1'b0, -1, 1'b0, 1'b0);

      applyStimulus(2, 3, 1'b1, 0, 1'b1, 1'b0);
      applyStimulus(1, 2, 1'b0, 0, 1'b1, 1'b1);
      applyStimulus(2, 2, 1'b1, 0, 1'b0, 1'b1);

      for (int i = 0; i < 14; i++) begin
         s = $urandom_range(0, 6);
         p = 0;
         if (s > 0 && $urandom_range(0, 3) == 0) p = $urandom_range(1, s);
         applyStimulus(s, $urandom_range(0, 6), 1'($urandom_range(0, 1)), p, 1'b0, 1'b0);
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboardEmpty", sbq.size(), 0);

      // Reset in the middle of a pulse must clear everything at once.
      cmdSteps = 16'd5;
      cmdHalf  = 20'd3;
      cmdDir   = 1'b1;
      cmdValid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmdValid = 1'b0;
      n = 0;
      while (!step && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      checkOutput("midMoveHigh", int'(step), 1);
      #2;
      clr = 1'b0;
      #1;
      checkOutput("midRstStep", int'(step), 0);
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstReady", int'(cmdReady), 1);
      checkOutput("midRstStepsLeft", int'(stepsLeft), 0);
      checkOutput("midRstDone", int'(done), 0);
      @(negedge clk);
      clr = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("postRstIdle", int'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
